raabb_slab_reducer: RTL and testbench

- Streaming reduction stage on the consumer side of the ray/AABB slab comparison path.
- Accepts per-slab (t_near, t_far) pairs in the 11/14 FloPoCo float format. Tracks running max(t_near) and min(t_far) across all beats of a ray.
- On the ray's last beat, emits the final interval and a hit decision.
- Decides ordering natively on the encoded format; no FP subtractor instance.

---
 rtl/raabb_slab_reducer.sv | 114 +++++++++++
 tb/tb_raabb_slab_reducer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/raabb_slab_reducer.sv
// rtl/raabb_slab_reducer.sv - ray/AABB slab interval reducer: running max(t_near), min(t_far), hit decision
// Ordering uses a signed magnitude key built from the encoded float; no arithmetic FP unit is needed.
module raabb_slab_reducer #(
  parameter int width = 27,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [width:0]   in_near,
  input  logic [width:0]   in_far,
  input  logic             in_last,
  output logic             out_valid,
  output logic [width:0]   out_tnear,
  output logic [width:0]   out_tfar,
  output logic             out_hit,
  output logic             out_nan,
  output logic [CNT_W-1:0] out_cnt
);
  localparam int W = width + 1;

  // Zeros of either sign and NaNs collapse to magnitude 0, so +0 == -0 and the order is total.
  function automatic logic signed [W-1:0] key_of(input logic [W-1:0] v);
    logic [W-2:0] mag;
    mag = '0;
    case (v[W-1:W-2])
      2'b01:   mag = {2'b01, v[W-4:0]};
      2'b10:   mag = {2'b10, {(W-3){1'b0}}};
      default: mag = '0;
    endcase
    key_of = v[W-3] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  logic                  s1_valid, s1_last, s1_nan;
  logic [W-1:0]          s1_near, s1_far;
  logic signed [W-1:0]   s1_kn, s1_kf;

  logic                  first, acc_done, acc_nan;
  logic [W-1:0]          acc_near, acc_far;
  logic signed [W-1:0]   acc_kn, acc_kf;
  logic [CNT_W-1:0]      acc_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_nan   <= 1'b0;
      s1_near  <= '0;
      s1_far   <= '0;
      s1_kn    <= '0;
      s1_kf    <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_last  <= in_valid & in_last;
      s1_nan   <= (in_near[W-1:W-2] == 2'b11) | (in_far[W-1:W-2] == 2'b11);
      s1_near  <= in_near;
      s1_far   <= in_far;
      s1_kn    <= key_of(in_near);
      s1_kf    <= key_of(in_far);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first    <= 1'b1;
      acc_done <= 1'b0;
      acc_nan  <= 1'b0;
      acc_near <= '0;
      acc_far  <= '0;
      acc_kn   <= '0;
      acc_kf   <= '0;
      acc_cnt  <= '0;
    end else begin
      acc_done <= s1_valid & s1_last;
      if (s1_valid) begin
        // Strict compares: on a tie the earlier encoding is kept.
        if (first || (s1_kn > acc_kn)) begin
          acc_near <= s1_near;
          acc_kn   <= s1_kn;
        end
        if (first || (s1_kf < acc_kf)) begin
          acc_far <= s1_far;
          acc_kf  <= s1_kf;
        end
        acc_nan <= first ? s1_nan : (acc_nan | s1_nan);
        if (first)
          acc_cnt <= CNT_W'(1);
        else if (acc_cnt != {CNT_W{1'b1}})
          acc_cnt <= acc_cnt + CNT_W'(1);
        first <= s1_last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_tnear <= '0;
      out_tfar  <= '0;
      out_hit   <= 1'b0;
      out_nan   <= 1'b0;
      out_cnt   <= '0;
    end else begin
      out_valid <= acc_done;
      if (acc_done) begin
        out_tnear <= acc_near;
        out_tfar  <= acc_far;
        out_nan   <= acc_nan;
        out_cnt   <= acc_cnt;
        out_hit   <= !acc_nan && (acc_kn <= acc_kf) && !acc_kf[W-1];
      end
    end
  end
endmodule

// File: tb/tb_raabb_slab_reducer.sv
// tb/tb_raabb_slab_reducer.sv - directed self-checking bench for raabb_slab_reducer
module tb_raabb_slab_reducer;
  localparam logic [27:0] ONE  = 28'h4FFC000;
  localparam logic [27:0] TWO  = 28'h5000000;
  localparam logic [27:0] THR  = 28'h5002000;
  localparam logic [27:0] HALF = 28'h4FF8000;
  localparam logic [27:0] MONE = 28'h6FFC000;
  localparam logic [27:0] MTWO = 28'h7000000;
  localparam logic [27:0] PZ   = 28'h0000000;
  localparam logic [27:0] MZ   = 28'h2000000;
  localparam logic [27:0] PINF = 28'h8000000;
  localparam logic [27:0] QNAN = 28'hC000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [27:0] in_near = '0;
  logic [27:0] in_far = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic [27:0] out_tnear;
  logic [27:0] out_tfar;
  logic        out_hit;
  logic        out_nan;
  logic [3:0]  out_cnt;

  int total = 0;
  int bad = 0;

  raabb_slab_reducer #(.width(27), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_near(in_near), .in_far(in_far),
    .in_last(in_last), .out_valid(out_valid), .out_tnear(out_tnear), .out_tfar(out_tfar),
    .out_hit(out_hit), .out_nan(out_nan), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one beat, let the next rising edge sample it, then settle 1 time unit past the edge.
  task automatic cyc(input logic v, input logic [27:0] n, input logic [27:0] f, input logic l);
    in_valid = v;
    in_near  = n;
    in_far   = f;
    in_last  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input logic [27:0] tn, input logic [27:0] tf,
                              input logic hit, input logic nan, input logic [3:0] cnt);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_tnear"}, {4'b0, out_tnear}, {4'b0, tn});
    check({tag, "_tfar"},  {4'b0, out_tfar},  {4'b0, tf});
    check({tag, "_hit"},   {31'b0, out_hit},  {31'b0, hit});
    check({tag, "_nan"},   {31'b0, out_nan},  {31'b0, nan});
    check({tag, "_cnt"},   {28'b0, out_cnt},  {28'b0, cnt});
  endtask

  initial begin
    #2;
    check("reset_valid", {31'b0, out_valid}, 32'd0);
    check("reset_tnear", {4'b0, out_tnear}, 32'd0);
    check("reset_cnt",   {28'b0, out_cnt}, 32'd0);
    cyc(0, PZ, PZ, 0);
    rst = 1'b0;
    cyc(0, PZ, PZ, 0);

    // Hit ray, 3 beats
    cyc(1, ONE, THR, 0);
    cyc(1, HALF, TWO, 0);
    cyc(1, ONE, TWO, 1);
    cyc(0, PZ, PZ, 0);
    check("hit_lat1", {31'b0, out_valid}, 32'd0);
    cyc(0, PZ, PZ, 0);
    check_result("hit", ONE, TWO, 1'b1, 1'b0, 4'd1 + 4'd2);
    cyc(0, PZ, PZ, 0);
    check("hit_pulse", {31'b0, out_valid}, 32'd0);

    // Miss (tnear > tfar)
    cyc(1, TWO, THR, 0);
    cyc(1, HALF, ONE, 1);
    cyc(0, PZ, PZ, 0);
    cyc(0, PZ, PZ, 0);
    check_result("miss", TWO, ONE, 1'b0, 1'b0, 4'd2);

    // Behind the ray origin, single beat
    cyc(1, MTWO, MONE, 1);
    cyc(0, PZ, PZ, 0);
    cyc(0, PZ, PZ, 0);
    check_result("behind", MTWO, MONE, 1'b0, 1'b0, 4'd1);

    // Signed-zero tie keeps the earlier +0
    cyc(1, PZ, PINF, 0);
    cyc(1, MZ, ONE, 1);
    cyc(0, PZ, PZ, 0);
    cyc(0, PZ, PZ, 0);
    check_result("zero", PZ, ONE, 1'b1, 1'b0, 4'd2);

    // NaN mid-ray, then a clean ray immediately after
    cyc(1, ONE, TWO, 0);
    cyc(1, ONE, QNAN, 0);
    cyc(1, HALF, THR, 1);
    cyc(1, HALF, ONE, 1);
    cyc(0, PZ, PZ, 0);
    check_result("nan", ONE, QNAN, 1'b0, 1'b1, 4'd3);
    cyc(0, PZ, PZ, 0);
    check_result("clean", HALF, ONE, 1'b1, 1'b0, 4'd1);

    // Streaming: rays of 1, 1, 2 beats with gaps
    cyc(1, ONE, TWO, 1);
    cyc(0, PZ, PZ, 0);
    check("strm_gap0", {31'b0, out_valid}, 32'd0);
    cyc(1, MTWO, MONE, 1);
    check_result("strm_a", ONE, TWO, 1'b1, 1'b0, 4'd1);
    cyc(1, HALF, THR, 0);
    check("strm_gap1", {31'b0, out_valid}, 32'd0);
    cyc(0, PZ, PZ, 0);
    check_result("strm_b", MTWO, MONE, 1'b0, 1'b0, 4'd1);
    cyc(1, TWO, THR, 1);
    cyc(0, PZ, PZ, 0);
    check("strm_gap2", {31'b0, out_valid}, 32'd0);
    cyc(0, PZ, PZ, 0);
    check_result("strm_c", TWO, THR, 1'b1, 1'b0, 4'd2);

    // Asynchronous reset mid-ray
    cyc(1, TWO, THR, 0);
    cyc(1, ONE, ONE, 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_tnear", {4'b0, out_tnear}, 32'd0);
    check("arst_tfar",  {4'b0, out_tfar}, 32'd0);
    check("arst_hit",   {31'b0, out_hit}, 32'd0);
    check("arst_cnt",   {28'b0, out_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, ONE, TWO, 1);
    cyc(0, PZ, PZ, 0);
    cyc(0, PZ, PZ, 0);
    check_result("post_rst", ONE, TWO, 1'b1, 1'b0, 4'd1);

    // 20-beat ray saturates the counter
    for (int i = 0; i < 20; i++) cyc(1, ONE, TWO, (i == 19));
    cyc(0, PZ, PZ, 0);
    cyc(0, PZ, PZ, 0);
    check_result("sat", ONE, TWO, 1'b1, 1'b0, 4'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
